// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: op classes, load/store
// sub-ops, bus widths and the transfer FSM states.
package mem_stage_pkg;

   localparam int OP_W       = 8;
   localparam int SUB_OP_W   = 4;
   localparam int REG_ADDR_W = 5;
   localparam int MEM_BYTE_W = 8;

   localparam logic [OP_W-1:0] EXE_NOP = 8'h00;
   localparam logic [OP_W-1:0] EXE_LB  = 8'h20;
   localparam logic [OP_W-1:0] EXE_SB  = 8'h28;

   localparam logic [SUB_OP_W-1:0] OP_LB  = 4'h0;
   localparam logic [SUB_OP_W-1:0] OP_LH  = 4'h1;
   localparam logic [SUB_OP_W-1:0] OP_LW  = 4'h2;
   localparam logic [SUB_OP_W-1:0] OP_LBU = 4'h4;
   localparam logic [SUB_OP_W-1:0] OP_LHU = 4'h5;
   localparam logic [SUB_OP_W-1:0] OP_SB  = 4'h8;
   localparam logic [SUB_OP_W-1:0] OP_SH  = 4'h9;
   localparam logic [SUB_OP_W-1:0] OP_SW  = 4'hA;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // Index of the final byte of a transfer: 0 for byte, 1 for half, 3 for word.
   function automatic logic [1:0] last_byte_idx(input logic [SUB_OP_W-1:0] sub_op);
      case (sub_op)
         OP_LB, OP_LBU, OP_SB: last_byte_idx = 2'd0;
         OP_LH, OP_LHU, OP_SH: last_byte_idx = 2'd1;
         default:              last_byte_idx = 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Sign/zero extension of an assembled little-endian load word.
module load_extend
   import mem_stage_pkg::*;
(
   input  logic [31:0]         word_i,
   input  logic [SUB_OP_W-1:0] sub_op_i,
   output logic [31:0]         ext_o
);

   always_comb begin
      case (sub_op_i)
         OP_LB:   ext_o = {{24{word_i[7]}}, word_i[7:0]};
         OP_LH:   ext_o = {{16{word_i[15]}}, word_i[15:0]};
         OP_LBU:  ext_o = {24'h000000, word_i[7:0]};
         OP_LHU:  ext_o = {16'h0000, word_i[15:0]};
         default: ext_o = word_i;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: ALU results pass through; loads/stores are serialised one byte
// per accepted cycle onto an 8-bit port while the pipeline is stalled.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [OP_W-1:0]       aluop_i,
   input  logic [SUB_OP_W-1:0]   sub_aluop_i,
   input  logic [31:0]           mem_addr_i,
   input  logic [31:0]           reg2_i,
   input  logic [REG_ADDR_W-1:0] wd_i,
   input  logic                  wreg_i,
   input  logic [31:0]           wdata_i,
   input  logic                  hold_i,
   output logic [REG_ADDR_W-1:0] wd_o,
   output logic                  wreg_o,
   output logic [31:0]           wdata_o,
   output logic                  mem_stall_o,
   output logic [ADDR_WIDTH-1:0] mem_a_o,
   output logic                  mem_wr_o,
   output logic [MEM_BYTE_W-1:0] mem_dout_o,
   input  logic [MEM_BYTE_W-1:0] mem_din_i,
   input  logic                  mem_busy_i
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           store_q, store_d;
   logic [SUB_OP_W-1:0]   sub_q, sub_d;
   logic [REG_ADDR_W-1:0] wd_q, wd_d;
   logic                  wreg_q, wreg_d;
   logic                  is_load_q, is_load_d;
   logic [1:0]            idx_q, idx_d;
   logic                  cap_vld_q, cap_vld_d;
   logic [1:0]            cap_idx_q, cap_idx_d;
   logic [31:0]           asm_q, asm_d;
   logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
   logic                  mem_wr_q, mem_wr_d;
   logic [MEM_BYTE_W-1:0] mem_dout_q, mem_dout_d;

   logic        is_load, is_store, is_mem;
   logic [1:0]  idx_nxt;
   logic [31:0] load_ext;

   assign is_load  = (aluop_i == EXE_LB);
   assign is_store = (aluop_i == EXE_SB);
   assign is_mem   = is_load | is_store;
   assign idx_nxt  = idx_q + 2'd1;

   load_extend u_load_extend (
      .word_i   (asm_q),
      .sub_op_i (sub_q),
      .ext_o    (load_ext)
   );

   // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      store_d    = store_q;
      sub_d      = sub_q;
      wd_d       = wd_q;
      wreg_d     = wreg_q;
      is_load_d  = is_load_q;
      idx_d      = idx_q;
      cap_vld_d  = 1'b0;
      cap_idx_d  = cap_idx_q;
      asm_d      = asm_q;
      mem_a_d    = mem_a_q;
      mem_wr_d   = mem_wr_q;
      mem_dout_d = mem_dout_q;

      case (state_q)
         ST_IDLE: begin
            if (is_mem) begin
               addr_d     = mem_addr_i[ADDR_WIDTH-1:0];
               store_d    = reg2_i;
               sub_d      = sub_aluop_i;
               wd_d       = wd_i;
               wreg_d     = wreg_i;
               is_load_d  = is_load;
               idx_d      = 2'd0;
               asm_d      = '0;
               mem_a_d    = mem_addr_i[ADDR_WIDTH-1:0];
               mem_wr_d   = is_store;
               mem_dout_d = reg2_i[7:0];
               state_d    = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (!mem_busy_i) begin
               cap_vld_d = is_load_q;
               cap_idx_d = idx_q;
               if (idx_q == last_byte_idx(sub_q)) begin
                  mem_wr_d = 1'b0;
                  state_d  = is_load_q ? ST_DRAIN : ST_DONE;
               end else begin
                  idx_d      = idx_nxt;
                  mem_a_d    = addr_q + ADDR_WIDTH'(idx_nxt);
                  mem_dout_d = store_q[{idx_nxt, 3'b000} +: 8];
               end
            end
         end
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE: begin
            if (!hold_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Read data trails its accepted address by one cycle, busy or not.
      if (cap_vld_q) asm_d[{cap_idx_q, 3'b000} +: 8] = mem_din_i;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         store_q    <= '0;
         sub_q      <= '0;
         wd_q       <= '0;
         wreg_q     <= 1'b0;
         is_load_q  <= 1'b0;
         idx_q      <= '0;
         cap_vld_q  <= 1'b0;
         cap_idx_q  <= '0;
         asm_q      <= '0;
         mem_a_q    <= '0;
         mem_wr_q   <= 1'b0;
         mem_dout_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         store_q    <= store_d;
         sub_q      <= sub_d;
         wd_q       <= wd_d;
         wreg_q     <= wreg_d;
         is_load_q  <= is_load_d;
         idx_q      <= idx_d;
         cap_vld_q  <= cap_vld_d;
         cap_idx_q  <= cap_idx_d;
         asm_q      <= asm_d;
         mem_a_q    <= mem_a_d;
         mem_wr_q   <= mem_wr_d;
         mem_dout_q <= mem_dout_d;
      end
   end

   assign mem_a_o    = mem_a_q;
   assign mem_wr_o   = mem_wr_q;
   assign mem_dout_o = mem_dout_q;

   // Write-back is suppressed while stalled so partial loads never forward.
   always_comb begin
      wd_o        = wd_i;
      wreg_o      = wreg_i;
      wdata_o     = wdata_i;
      mem_stall_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (is_mem) begin
               mem_stall_o = 1'b1;
               wreg_o      = 1'b0;
            end
         end
         ST_ACCESS, ST_DRAIN: begin
            mem_stall_o = 1'b1;
            wreg_o      = 1'b0;
            wd_o        = wd_q;
         end
         ST_DONE: begin
            wd_o    = wd_q;
            wreg_o  = wreg_q;
            wdata_o = is_load_q ? load_ext : wdata_i;
         end
         default: ;
      endcase
      if (!rst) begin
         wd_o        = '0;
         wreg_o      = 1'b0;
         wdata_o     = '0;
         mem_stall_o = 1'b0;
      end
   end

endmodule
